boosted_reg_bank: RTL

- Register bank with single-level boosting support for speculative execution.
- Holds NUM_REGS architectural registers, each with one shadow (boosted) copy and a valid bit.
- Written from the C-latch writeback bus; drives two registered read buses (A, B) to the ALU input latches.
- Shadow copies are promoted to the architectural registers on branch commit, or discarded on squash.

---
 rtl/reg_bank_pkg.sv | 41 ++++
 rtl/boosted_reg_bank_if.sv | 45 ++++
 rtl/boost_shadow_file.sv | 72 +++++++
 rtl/boosted_reg_bank.sv | 103 ++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_pkg
// Shared constants and types for the boosted register bank.
//   DATA_W   : register / bus width
//   NUM_REGS : number of architectural registers (register 0 reads as zero)
//   ADDR_W   : register address width
//   ZERO_REG : index of the hardwired zero register
// Also provides the speculation-control decode used by the shadow file.
// -----------------------------------------------------------------------------
package reg_bank_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef logic [DATA_W-1:0]                 word_t;
    typedef logic [ADDR_W-1:0]                 addr_t;
    typedef logic [NUM_REGS-1:0]               reg_mask_t;
    typedef logic [NUM_REGS-1:0][DATA_W-1:0]   reg_array_t;

    // Speculation outcome for one cycle.
    typedef enum logic [1:0] {
        SPEC_HOLD   = 2'd0,
        SPEC_COMMIT = 2'd1,
        SPEC_SQUASH = 2'd2
    } spec_op_e;

    // A mispredict overrides a simultaneous commit.
    function automatic spec_op_e decode_spec_op(input logic commit, input logic squash);
        if (squash) begin
            return SPEC_SQUASH;
        end
        if (commit) begin
            return SPEC_COMMIT;
        end
        return SPEC_HOLD;
    endfunction

endpackage

// File: rtl/boosted_reg_bank_if.sv
// -----------------------------------------------------------------------------
// boosted_reg_bank_if
// Bundles the writeback bus, the two read ports, the speculation controls and
// the status outputs of the boosted register bank.
//   master : pipeline side (drives writes, reads, commit/squash)
//   slave  : register bank side
// -----------------------------------------------------------------------------
interface boosted_reg_bank_if;
    import reg_bank_pkg::*;

    // Writeback from the C latch
    logic      wr_en;
    logic      wr_boost;
    addr_t     wr_addr;
    word_t     from_c_latch;

    // Read ports towards the ALU input latches
    addr_t     rd_addr_a;
    addr_t     rd_addr_b;
    logic      rd_boost_a;
    logic      rd_boost_b;
    word_t     bus_a;
    word_t     bus_b;

    // Speculation control and status
    logic      commit;
    logic      squash;
    reg_mask_t shadow_valid;
    logic      boost_pending;

    modport master (
        output wr_en, wr_boost, wr_addr, from_c_latch,
        output rd_addr_a, rd_addr_b, rd_boost_a, rd_boost_b,
        output commit, squash,
        input  bus_a, bus_b, shadow_valid, boost_pending
    );

    modport slave (
        input  wr_en, wr_boost, wr_addr, from_c_latch,
        input  rd_addr_a, rd_addr_b, rd_boost_a, rd_boost_b,
        input  commit, squash,
        output bus_a, bus_b, shadow_valid, boost_pending
    );

endinterface

// File: rtl/boost_shadow_file.sv
// -----------------------------------------------------------------------------
// boost_shadow_file
// Shadow (boosted) copy of every register plus its valid bit, and the
// priority between boosted writes, commit and squash.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   wr_en, wr_boost,
//   wr_addr, wr_data      : writeback bus (only boosted writes land here)
//   commit, squash        : branch outcome for this cycle
//   shadow_q, valid_q     : current shadow contents / valid mask
//   shadow_d, valid_d     : contents / mask after the coming edge
//   promote               : registers whose shadow moves to architectural
//                           state at the coming edge
// -----------------------------------------------------------------------------
module boost_shadow_file
    import reg_bank_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic       wr_boost,
    input  addr_t      wr_addr,
    input  word_t      wr_data,
    input  logic       commit,
    input  logic       squash,
    output reg_array_t shadow_q,
    output reg_array_t shadow_d,
    output reg_mask_t  valid_q,
    output reg_mask_t  valid_d,
    output reg_mask_t  promote
);

    spec_op_e spec_op;
    logic     boost_wr;

    assign spec_op  = decode_spec_op(commit, squash);
    assign boost_wr = wr_en && wr_boost && (wr_addr != ZERO_REG);

    // The boosted write is applied after the commit/squash clear: it belongs
    // to the next speculation level, so its valid bit survives this edge.
    // Promotion uses the pre-edge shadow, so a boosted write to a register
    // being committed promotes the old shadow and keeps the new one pending.
    always_comb begin
        shadow_d = shadow_q;
        valid_d  = valid_q;
        promote  = '0;

        if (spec_op == SPEC_COMMIT) begin
            promote = valid_q;
        end

        if (spec_op != SPEC_HOLD) begin
            valid_d = '0;
        end

        if (boost_wr) begin
            shadow_d[wr_addr] = wr_data;
            valid_d[wr_addr]  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
            valid_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: rtl/boosted_reg_bank.sv
// -----------------------------------------------------------------------------
// boosted_reg_bank
// Architectural register file with one level of boosting for speculative
// execution. Each register has a shadow copy that boosted instructions write;
// shadows are promoted on commit or dropped on squash.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, overrides every other input
//   rb    : boosted_reg_bank_if.slave
//           wr_en/wr_boost/wr_addr/from_c_latch : writeback bus
//           rd_addr_x/rd_boost_x                : read requests, ports A/B
//           commit/squash                       : branch outcome
//           bus_a/bus_b                         : registered read data
//           shadow_valid/boost_pending          : speculation status
// -----------------------------------------------------------------------------
module boosted_reg_bank
    import reg_bank_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    boosted_reg_bank_if.slave  rb
);

    reg_array_t arch_q;
    reg_array_t arch_d;
    reg_array_t shadow_q;
    reg_array_t shadow_d;
    reg_mask_t  valid_q;
    reg_mask_t  valid_d;
    reg_mask_t  promote;
    logic       arch_wr;
    word_t      rd_a_p1;
    word_t      rd_b_p1;

    // Read select. Reads are taken from the post-edge state, which gives the
    // write-through bypass and commit/squash visibility in one rule.
    function automatic word_t read_sel(
        input addr_t      addr,
        input logic       boost,
        input reg_mask_t  vld,
        input reg_array_t arch,
        input reg_array_t shadow
    );
        if (addr == ZERO_REG) begin
            return '0;
        end
        if (boost && vld[addr]) begin
            return shadow[addr];
        end
        return arch[addr];
    endfunction

    boost_shadow_file u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (rb.wr_en),
        .wr_boost (rb.wr_boost),
        .wr_addr  (rb.wr_addr),
        .wr_data  (rb.from_c_latch),
        .commit   (rb.commit),
        .squash   (rb.squash),
        .shadow_q (shadow_q),
        .shadow_d (shadow_d),
        .valid_q  (valid_q),
        .valid_d  (valid_d),
        .promote  (promote)
    );

    assign arch_wr = rb.wr_en && !rb.wr_boost && (rb.wr_addr != ZERO_REG);

    // A non-boosted write is younger in program order than the boosted
    // instructions being committed, so it beats promotion of the same register.
    always_comb begin
        arch_d = arch_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (arch_wr && (rb.wr_addr == ADDR_W'(i))) begin
                arch_d[i] = rb.from_c_latch;
            end else if (promote[i]) begin
                arch_d[i] = shadow_q[i];
            end
        end
        arch_d[0] = '0;
    end

    // ---- stage p0 -> p1: state update and registered read ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arch_q  <= '0;
            rd_a_p1 <= '0;
            rd_b_p1 <= '0;
        end else begin
            arch_q  <= arch_d;
            rd_a_p1 <= read_sel(rb.rd_addr_a, rb.rd_boost_a, valid_d, arch_d, shadow_d);
            rd_b_p1 <= read_sel(rb.rd_addr_b, rb.rd_boost_b, valid_d, arch_d, shadow_d);
        end
    end

    assign rb.bus_a         = rd_a_p1;
    assign rb.bus_b         = rd_b_p1;
    assign rb.shadow_valid  = valid_q;
    assign rb.boost_pending = |valid_q;

endmodule
